pipeline_hazard_ctrl: RTL

//  Control end of the pipeline registers: watches source/dest fields leaving D/E/M/W and

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_fwd_sel.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes, wait-FSM
// state encoding and a register-match helper used by forwarding and load-use detection.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam int unsigned REG_W = 5;

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one E-stage operand; the M-stage ALU result wins over the
// W-stage result because it is the younger producer.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] Rs,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    output fwd_sel_e         fwd_sel
);

    always_comb begin
        fwd_sel = FWD_NONE;
        if (RegWriteM && reg_hit(RdM, Rs)) begin
            fwd_sel = FWD_MEM;
        end else if (RegWriteW && reg_hit(RdW, Rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: forwarding, load-use stall, branch flush and a
// data-memory wait FSM. Perf counters are built only when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        Rs1E,
    input  logic [4:0]        Rs2E,
    input  logic [4:0]        RdE,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic [4:0]        RdM,
    input  logic [4:0]        RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              dmem_req_M,
    input  logic              dmem_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam logic [TO_W-1:0] TimeoutLast = TO_W'(MEM_TIMEOUT - 1);

    hz_state_e       state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic            mem_wait;
    logic            lw_stall;
    fwd_sel_e        fwd_a, fwd_b;

    hazard_fwd_sel u_fwd_a (
        .Rs        (Rs1E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .fwd_sel   (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .Rs        (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .fwd_sel   (fwd_b)
    );

    assign lw_stall = LoadE && (reg_hit(RdE, Rs1D) || reg_hit(RdE, Rs2D));

    // Wait FSM: the stall is raised in the same cycle the request is seen not ready.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        mem_wait   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (dmem_req_M && !dmem_ready) begin
                    mem_wait   = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    mem_wait = 1'b1;
                    if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + TO_W'(1);
                    end
                    if (wait_cnt_q == TimeoutLast) begin
                        mem_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    // A held E stage re-presents PCSrcE/LoadE once the memory wait releases.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_wait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;
    logic              any_stall;
    logic              branch_flush;

    assign any_stall    = StallF || StallD || StallE || StallM;
    assign branch_flush = !rst && !mem_wait && PCSrcE;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (any_stall) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (branch_flush) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
